// File: rtl/specreg_pkg.sv
// Shared encodings for the special-register flag path: update modes, ALU kinds,
// scheduler states and round-robin pointer values.
package specreg_pkg;

    typedef enum logic [3:0] {
        UPD_NONE     = 4'd0,
        UPD_BS       = 4'd1,
        UPD_ADD      = 4'd2,
        UPD_MOV      = 4'd3,
        UPD_V        = 4'd4,
        UPD_SWI      = 4'd5,
        UPD_BIOS_OFF = 4'd7
    } update_mode_t;

    typedef enum logic [1:0] {
        KIND_ADD  = 2'd0,
        KIND_MOV  = 2'd1,
        KIND_V    = 2'd2,
        KIND_RSVD = 2'd3
    } alu_kind_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SWI_ISSUE,
        ST_SWI_CHECK,
        ST_BIOS_ISSUE,
        ST_BIOS_WAIT
    } sched_state_t;

    localparam logic RR_ALU = 1'b0;
    localparam logic RR_BS  = 1'b1;

    function automatic update_mode_t alu_mode(input logic [1:0] kind);
        case (kind)
            KIND_ADD: return UPD_ADD;
            KIND_MOV: return UPD_MOV;
            KIND_V:   return UPD_V;
            default:  return UPD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: req[0]/gnt[0] is the ALU side, req[1]/gnt[1] the
// shifter side. The pointer moves away from whichever side was last granted.
import specreg_pkg::*;

module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic prio;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (prio == RR_BS) ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            prio <= RR_ALU;
        end else if (gnt[0]) begin
            prio <= RR_BS;
        end else if (gnt[1]) begin
            prio <= RR_ALU;
        end
    end

endmodule

// File: rtl/flag_update_scheduler.sv
// Schedules flag-register updates from ALU, shifter, SWI and BIOS-exit requesters;
// all outputs are registered and follow the sampling edge by one cycle.
import specreg_pkg::*;

module flag_update_scheduler (
    input  logic       clock,
    input  logic       reset,
    input  logic       stall,
    input  logic       alu_req,
    input  logic [1:0] alu_kind,
    input  logic       bs_req,
    input  logic       swi_req,
    input  logic       bios_exit_req,
    input  logic       mode_flag,
    input  logic       is_bios,
    output logic       spec_enable,
    output logic [3:0] update_mode,
    output logic       alu_grant,
    output logic       bs_grant,
    output logic       swi_grant,
    output logic       bios_grant,
    output logic       swi_done,
    output logic       swi_fault,
    output logic       busy
);

    sched_state_t state;
    logic         saved_mode;
    logic         alu_elig, bs_elig, swi_elig, bios_elig, arb_en;
    logic [1:0]   arb_req, arb_gnt;

    // A grant showing this cycle is the ack; the requester drops req afterwards.
    assign alu_elig  = alu_req && !alu_grant && (alu_kind != KIND_RSVD);
    assign bs_elig   = bs_req && !bs_grant;
    assign swi_elig  = swi_req && !swi_grant;
    assign bios_elig = bios_exit_req && !bios_grant;
    assign arb_en    = (state == ST_IDLE) && !stall && !bios_elig && !swi_elig;
    assign arb_req   = {bs_elig, alu_elig} & {2{arb_en}};

    rr_arb2 u_rr (
        .clock (clock),
        .reset (reset),
        .req   (arb_req),
        .gnt   (arb_gnt)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= ST_IDLE;
            saved_mode  <= 1'b0;
            spec_enable <= 1'b0;
            update_mode <= UPD_NONE;
            alu_grant   <= 1'b0;
            bs_grant    <= 1'b0;
            swi_grant   <= 1'b0;
            bios_grant  <= 1'b0;
            swi_done    <= 1'b0;
            swi_fault   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            spec_enable <= 1'b0;
            update_mode <= UPD_NONE;
            alu_grant   <= 1'b0;
            bs_grant    <= 1'b0;
            swi_grant   <= 1'b0;
            bios_grant  <= 1'b0;
            swi_done    <= 1'b0;
            swi_fault   <= 1'b0;
            if (!stall) begin
                case (state)
                    ST_IDLE: begin
                        if (bios_elig) begin
                            bios_grant <= 1'b1;
                            // Already out of BIOS: acknowledge without touching the flags.
                            if (is_bios) begin
                                state       <= ST_BIOS_ISSUE;
                                spec_enable <= 1'b1;
                                update_mode <= UPD_BIOS_OFF;
                                busy        <= 1'b1;
                            end
                        end else if (swi_elig) begin
                            state       <= ST_SWI_ISSUE;
                            saved_mode  <= mode_flag;
                            swi_grant   <= 1'b1;
                            spec_enable <= 1'b1;
                            update_mode <= UPD_SWI;
                            busy        <= 1'b1;
                        end else if (arb_gnt[0]) begin
                            alu_grant   <= 1'b1;
                            spec_enable <= 1'b1;
                            update_mode <= alu_mode(alu_kind);
                        end else if (arb_gnt[1]) begin
                            bs_grant    <= 1'b1;
                            spec_enable <= 1'b1;
                            update_mode <= UPD_BS;
                        end
                    end
                    ST_SWI_ISSUE: state <= ST_SWI_CHECK;
                    ST_SWI_CHECK: begin
                        swi_done  <= (mode_flag != saved_mode);
                        swi_fault <= (mode_flag == saved_mode);
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                    end
                    ST_BIOS_ISSUE: state <= ST_BIOS_WAIT;
                    ST_BIOS_WAIT: begin
                        if (!is_bios) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_flag_update_scheduler.sv
// Self-checking bench for flag_update_scheduler: directed vector table, hand-written
// SWI/BIOS/stall/reset sequences, then random stimulus against a behavioural model.
module tb_flag_update_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       stall = 1'b0;
    logic       alu_req = 1'b0;
    logic [1:0] alu_kind = 2'd0;
    logic       bs_req = 1'b0;
    logic       swi_req = 1'b0;
    logic       bios_exit_req = 1'b0;
    logic       mode_flag = 1'b0;
    logic       is_bios = 1'b0;
    logic       spec_enable;
    logic [3:0] update_mode;
    logic       alu_grant, bs_grant, swi_grant, bios_grant, swi_done, swi_fault, busy;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    flag_update_scheduler dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .alu_req       (alu_req),
        .alu_kind      (alu_kind),
        .bs_req        (bs_req),
        .swi_req       (swi_req),
        .bios_exit_req (bios_exit_req),
        .mode_flag     (mode_flag),
        .is_bios       (is_bios),
        .spec_enable   (spec_enable),
        .update_mode   (update_mode),
        .alu_grant     (alu_grant),
        .bs_grant      (bs_grant),
        .swi_grant     (swi_grant),
        .bios_grant    (bios_grant),
        .swi_done      (swi_done),
        .swi_fault     (swi_fault),
        .busy          (busy)
    );

    // Packed view: {spec_enable, update_mode, alu, bs, swi, bios, done, fault, busy}
    logic [11:0] act;
    assign act = {spec_enable, update_mode, alu_grant, bs_grant, swi_grant, bios_grant,
                  swi_done, swi_fault, busy};

    function automatic logic [11:0] pk(input logic se, input logic [3:0] um, input logic ag,
                                       input logic bg, input logic sg, input logic xg,
                                       input logic sd, input logic sf, input logic bz);
        return {se, um, ag, bg, sg, xg, sd, sf, bz};
    endfunction

    task automatic check(input string name, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %03h expected %03h (se,mode,ag,bg,sg,xg,done,fault,busy)",
                     name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    typedef struct {
        logic        rst_n;
        logic        alu;
        logic [1:0]  kind;
        logic        bs;
        logic        bios;
        logic        isb;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[14];

    // Behavioural reference: seq 0 = free, 1 = SWI sequence, 2 = BIOS sequence.
    int   m_seq, m_step;
    logic m_saved, m_fav_alu;
    logic e_se, e_ag, e_bg, e_sg, e_xg, e_sd, e_sf, e_bz;
    logic [3:0] e_um;

    task automatic model_step();
        logic a_ok, b_ok, s_ok, x_ok;
        a_ok = alu_req && !e_ag && (alu_kind != 2'd3);
        b_ok = bs_req && !e_bg;
        s_ok = swi_req && !e_sg;
        x_ok = bios_exit_req && !e_xg;
        {e_se, e_um, e_ag, e_bg, e_sg, e_xg, e_sd, e_sf} = '0;
        if (!reset) begin
            m_seq = 0; m_step = 0; m_saved = 1'b0; m_fav_alu = 1'b1; e_bz = 1'b0;
        end else if (!stall) begin
            if (m_seq == 0) begin
                if (x_ok) begin
                    e_xg = 1'b1;
                    if (is_bios) begin e_um = 4'd7; m_seq = 2; m_step = 0; end
                end else if (s_ok) begin
                    e_sg = 1'b1; e_um = 4'd5; m_seq = 1; m_step = 0; m_saved = mode_flag;
                end else if (a_ok && (!b_ok || m_fav_alu)) begin
                    e_ag = 1'b1;
                    e_um = (alu_kind == 2'd0) ? 4'd2 : (alu_kind == 2'd1) ? 4'd3 : 4'd4;
                    m_fav_alu = 1'b0;
                end else if (b_ok) begin
                    e_bg = 1'b1; e_um = 4'd1; m_fav_alu = 1'b1;
                end
            end else if (m_seq == 1) begin
                if (m_step == 0) m_step = 1;
                else begin
                    e_sd = (mode_flag != m_saved); e_sf = !e_sd; m_seq = 0;
                end
            end else begin
                if (m_step == 0) m_step = 1;
                else if (!is_bios) m_seq = 0;
            end
            e_se = (e_um != 4'd0);
            e_bz = (m_seq != 0);
        end
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, pk(1, 2, 1, 0, 0, 0, 0, 0, 0)};
        tbl[2]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[3]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[4]  = '{1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, pk(1, 3, 1, 0, 0, 0, 0, 0, 0)};
        tbl[5]  = '{1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, pk(1, 1, 0, 1, 0, 0, 0, 0, 0)};
        tbl[6]  = '{1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, pk(1, 3, 1, 0, 0, 0, 0, 0, 0)};
        tbl[7]  = '{1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, pk(1, 1, 0, 1, 0, 0, 0, 0, 0)};
        tbl[8]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[9]  = '{1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[10] = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, pk(1, 4, 1, 0, 0, 0, 0, 0, 0)};
        tbl[11] = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, pk(1, 1, 0, 1, 0, 0, 0, 0, 0)};
        tbl[12] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, pk(0, 0, 0, 0, 0, 1, 0, 0, 0)};
        tbl[13] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0)};

        @(negedge clock);
        for (int i = 0; i < 14; i++) begin
            reset = tbl[i].rst_n; alu_req = tbl[i].alu; alu_kind = tbl[i].kind;
            bs_req = tbl[i].bs; bios_exit_req = tbl[i].bios; is_bios = tbl[i].isb;
            cyc();
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // SWI, flag register toggles the mode flag -> done two cycles after grant
        swi_req = 1'b1; mode_flag = 1'b0;
        cyc(); check("swi_grant", pk(1, 5, 0, 0, 1, 0, 0, 0, 1));
        swi_req = 1'b0; mode_flag = 1'b1;
        cyc(); check("swi_check", pk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        cyc(); check("swi_done", pk(0, 0, 0, 0, 0, 0, 1, 0, 0));
        cyc(); check("swi_after", pk(0, 0, 0, 0, 0, 0, 0, 0, 0));

        // SWI, toggle withheld -> fault
        swi_req = 1'b1;
        cyc(); check("swif_grant", pk(1, 5, 0, 0, 1, 0, 0, 0, 1));
        swi_req = 1'b0;
        cyc(); check("swif_check", pk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        cyc(); check("swi_fault", pk(0, 0, 0, 0, 0, 0, 0, 1, 0));

        // BIOS exit with an ALU request pending throughout
        is_bios = 1'b1; bios_exit_req = 1'b1; alu_req = 1'b1; alu_kind = 2'd0;
        cyc(); check("bios_grant", pk(1, 7, 0, 0, 0, 1, 0, 0, 1));
        bios_exit_req = 1'b0;
        cyc(); check("bios_wait1", pk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        cyc(); check("bios_wait2", pk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        is_bios = 1'b0;
        cyc(); check("bios_exit", pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(); check("alu_after_bios", pk(1, 2, 1, 0, 0, 0, 0, 0, 0));
        alu_req = 1'b0;

        // Stall across the SWI issue cycle
        mode_flag = 1'b0; swi_req = 1'b1;
        cyc(); check("stl_grant", pk(1, 5, 0, 0, 1, 0, 0, 0, 1));
        swi_req = 1'b0; stall = 1'b1;
        cyc(); check("stl_hold1", pk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        cyc(); check("stl_hold2", pk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        stall = 1'b0; mode_flag = 1'b1;
        cyc(); check("stl_check", pk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        cyc(); check("stl_done", pk(0, 0, 0, 0, 0, 0, 1, 0, 0));

        // Reset in the middle of BIOS_WAIT
        is_bios = 1'b1; bios_exit_req = 1'b1;
        cyc(); check("rst_bgrant", pk(1, 7, 0, 0, 0, 1, 0, 0, 1));
        bios_exit_req = 1'b0;
        cyc(); check("rst_wait", pk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        reset = 1'b0;
        cyc(); check("rst_mid_bios", pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;
        cyc(); check("rst_after", pk(0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Random stimulus against the behavioural model
        for (int i = 0; i < 3000; i++) begin
            reset         = (i == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
            stall         = ($urandom_range(0, 7) == 0);
            alu_req       = $urandom_range(0, 1);
            alu_kind      = 2'($urandom_range(0, 3));
            bs_req        = $urandom_range(0, 1);
            swi_req       = ($urandom_range(0, 5) == 0);
            bios_exit_req = ($urandom_range(0, 7) == 0);
            mode_flag     = $urandom_range(0, 1);
            is_bios       = $urandom_range(0, 1);
            model_step();
            cyc();
            check($sformatf("rand%0d", i),
                  pk(e_se, e_um, e_ag, e_bg, e_sg, e_xg, e_sd, e_sf, e_bz));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
